// File: rtl/noc_params.sv
// Shared NoC types: flit format, labels, output ports and XY routing helper.
package noc_params;

  localparam int VC_SIZE        = 1;
  localparam int DEST_ADDR_SIZE = 4;
  localparam int PAYLOAD_W      = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_VA     = 2'd1,
    VC_ACTIVE = 2'd2
  } vc_state_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [DEST_ADDR_SIZE-1:0] x_dest;
    logic [DEST_ADDR_SIZE-1:0] y_dest;
    logic [PAYLOAD_W-1:0]      data;
  } flit_t;

  // Dimension-order routing: resolve X first; Y grows towards SOUTH.
  function automatic port_t xy_route(input logic [DEST_ADDR_SIZE-1:0] xd,
                                     input logic [DEST_ADDR_SIZE-1:0] yd,
                                     input logic [DEST_ADDR_SIZE-1:0] xc,
                                     input logic [DEST_ADDR_SIZE-1:0] yc);
    if (xd > xc) return EAST;
    if (xd < xc) return WEST;
    if (yd > yc) return SOUTH;
    if (yd < yc) return NORTH;
    return LOCAL;
  endfunction

endpackage

// File: rtl/circular_buffer.sv
// Per-VC flit FIFO; a push to a full buffer is dropped, a pop of an empty one ignored.
module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  logic  i_pop,
  input  flit_t i_data,
  output flit_t o_data,
  output logic  o_empty,
  output logic  o_full
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  flit_t            r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok, w_pop_ok;

  // Fullness is judged before the edge, so a same-cycle pop never frees the slot.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(BUFFER_SIZE));

endmodule

// File: rtl/vc_input_port.sv
// Router input port: per-VC buffering, IDLE/VA/ACTIVE control and a registered crossbar flit.
module vc_input_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_NUM      = 2,
  parameter int X_CURRENT   = 0,
  parameter int Y_CURRENT   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  flit_t                           data_i,
  input  logic                            valid_flit_i,
  input  logic [VC_NUM-1:0]               va_grant_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]  va_new_vc_i,
  input  logic [VC_NUM-1:0]               sa_grant_i,
  output port_t [VC_NUM-1:0]              out_port_o,
  output logic [VC_NUM-1:0]               va_request_o,
  output logic [VC_NUM-1:0]               sa_request_o,
  output flit_t                           flit_o,
  output logic                            valid_flit_o,
  output logic [VC_NUM-1:0]               credit_o,
  output logic                            overflow_o
);

  localparam logic [DEST_ADDR_SIZE-1:0] X_CUR = DEST_ADDR_SIZE'(X_CURRENT);
  localparam logic [DEST_ADDR_SIZE-1:0] Y_CUR = DEST_ADDR_SIZE'(Y_CURRENT);

  flit_t [VC_NUM-1:0]              w_head;
  logic  [VC_NUM-1:0]              w_push, w_pop, w_empty, w_full, w_lbl_err;
  logic  [VC_NUM-1:0][VC_SIZE-1:0] w_new_vc;
  logic                            w_sa_onehot, w_deq_any;
  flit_t                           w_deq_flit;

  // Multi-bit grants are a protocol error upstream and are ignored outright.
  assign w_sa_onehot = (sa_grant_i != '0) && ((sa_grant_i & (sa_grant_i - 1'b1)) == '0);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_state_t          r_state, w_state_nxt;
    port_t              r_out_port;
    logic [VC_SIZE-1:0] r_new_vc;
    logic               w_is_head, w_is_tail;

    assign w_push[v] = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));

    circular_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[v]),
      .i_pop   (w_pop[v]),
      .i_data  (data_i),
      .o_data  (w_head[v]),
      .o_empty (w_empty[v]),
      .o_full  (w_full[v])
    );

    assign w_is_head    = (w_head[v].flit_label == HEAD) || (w_head[v].flit_label == HEADTAIL);
    assign w_is_tail    = (w_head[v].flit_label == TAIL) || (w_head[v].flit_label == HEADTAIL);
    assign w_pop[v]     = w_sa_onehot && sa_grant_i[v] && (r_state == VC_ACTIVE) && !w_empty[v];
    assign w_lbl_err[v] = (r_state == VC_IDLE) && !w_empty[v] && !w_is_head;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= VC_IDLE;
      else      r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        VC_IDLE:   if (!w_empty[v] && w_is_head) w_state_nxt = VC_VA;
        VC_VA:     if (va_grant_i[v])            w_state_nxt = VC_ACTIVE;
        VC_ACTIVE: if (w_pop[v] && w_is_tail)    w_state_nxt = VC_IDLE;
        default:                                 w_state_nxt = VC_IDLE;
      endcase
    end

    // Route and downstream VC are held for the whole packet.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_out_port <= LOCAL;
        r_new_vc   <= '0;
      end else begin
        if (r_state == VC_IDLE && w_state_nxt == VC_VA)
          r_out_port <= xy_route(w_head[v].x_dest, w_head[v].y_dest, X_CUR, Y_CUR);
        if (r_state == VC_VA && va_grant_i[v])
          r_new_vc <= va_new_vc_i[v];
      end
    end

    assign out_port_o[v]   = r_out_port;
    assign w_new_vc[v]     = r_new_vc;
    assign va_request_o[v] = (r_state == VC_VA);
    assign sa_request_o[v] = (r_state == VC_ACTIVE) && !w_empty[v];
  end

  assign w_deq_any = |w_pop;

  always_comb begin
    w_deq_flit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_pop[v]) begin
        w_deq_flit       = w_head[v];
        w_deq_flit.vc_id = w_new_vc[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_o       <= '0;
      valid_flit_o <= 1'b0;
      credit_o     <= '0;
      overflow_o   <= 1'b0;
    end else begin
      valid_flit_o <= w_deq_any;
      credit_o     <= w_pop;
      if (w_deq_any) flit_o <= w_deq_flit;
      if (|(w_push & w_full) || |w_lbl_err) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_port.sv
// Scoreboard bench: expected crossbar flits queued per source VC as written, matched as they leave.
module tb_vc_input_port;
  import noc_params::*;

  localparam int VN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  flit_t data_i;
  logic valid_flit_i;
  logic [VN-1:0] va_grant_i, sa_grant_i;
  logic [VN-1:0][VC_SIZE-1:0] va_new_vc_i;
  port_t [VN-1:0] out_port_o;
  logic [VN-1:0] va_request_o, sa_request_o, credit_o;
  flit_t flit_o;
  logic valid_flit_o, overflow_o;

  int checks = 0, errors = 0, cyc = 0, rr = 0;
  int credit_cnt [VN];
  flit_t wr_q[$], obs_q[$], exp0_q[$], exp1_q[$];
  int obs_cyc[$];

  vc_input_port #(.BUFFER_SIZE(8), .VC_NUM(VN), .X_CURRENT(0), .Y_CURRENT(0)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .va_grant_i(va_grant_i), .va_new_vc_i(va_new_vc_i), .sa_grant_i(sa_grant_i),
    .out_port_o(out_port_o), .va_request_o(va_request_o), .sa_request_o(sa_request_o),
    .flit_o(flit_o), .valid_flit_o(valid_flit_o), .credit_o(credit_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (valid_flit_o) begin obs_q.push_back(flit_o); obs_cyc.push_back(cyc); end
    for (int v = 0; v < VN; v++) if (credit_o[v]) credit_cnt[v]++;
  end

  function automatic flit_t mk(flit_label_t l, int vc, int x, int y, int d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_SIZE'(vc);
    f.x_dest     = DEST_ADDR_SIZE'(x);
    f.y_dest     = DEST_ADDR_SIZE'(y);
    f.data       = PAYLOAD_W'(d);
    return f;
  endfunction

  // The bench always grants downstream vc 1 to input vc0 and vc 0 to input vc1.
  function automatic flit_t out_of(flit_t f);
    flit_t o = f;
    o.vc_id = ~f.vc_id;
    return o;
  endfunction

  task automatic push_pkt(flit_t f);
    wr_q.push_back(f);
    if (f.vc_id == 0) exp0_q.push_back(out_of(f));
    else              exp1_q.push_back(out_of(f));
  endtask

  // mode 0: no grants, 1: VA grants only, 2: VA grants plus round-robin SA grants
  task automatic run(int n, int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr_q.size() > 0) begin data_i = wr_q.pop_front(); valid_flit_i = 1'b1; end
      else valid_flit_i = 1'b0;
      va_grant_i = (mode >= 1) ? va_request_o : '0;
      sa_grant_i = '0;
      if (mode == 2) begin
        if (sa_request_o[rr]) sa_grant_i[rr] = 1'b1;
        else if (sa_request_o[1-rr]) sa_grant_i[1-rr] = 1'b1;
        rr = 1 - rr;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; valid_flit_i = 1'b0; va_grant_i = '0; sa_grant_i = '0;
    wr_q.delete(); obs_q.delete(); obs_cyc.delete(); exp0_q.delete(); exp1_q.delete();
    credit_cnt[0] = 0; credit_cnt[1] = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    valid_flit_i = 1'b0; va_grant_i = '0; sa_grant_i = '0; data_i = '0;
    va_new_vc_i[0] = 1'b1; va_new_vc_i[1] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_port_o[0] !== LOCAL || out_port_o[1] !== LOCAL) begin errors++; $display("FAIL reset_out_port got=%h exp=LOCAL", out_port_o); end
    checks++; if ({va_request_o, sa_request_o, credit_o} !== 6'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", {va_request_o, sa_request_o, credit_o}); end
    checks++; if ({valid_flit_o, overflow_o} !== 2'b0 || flit_o !== flit_t'(0)) begin errors++; $display("FAIL reset_flit got=%b/%h exp=0", {valid_flit_o, overflow_o}, flit_o); end
    rst = 1'b1;
  endtask

  task automatic test_headtail();
    flit_t f;
    do_reset();
    @(negedge clk);
    f = mk(HEADTAIL, 0, 2, 0, 16'h1111);
    data_i = f; valid_flit_i = 1'b1; exp0_q.push_back(out_of(f));
    @(negedge clk); valid_flit_i = 1'b0;
    checks++; if (va_request_o !== 2'b00) begin errors++; $display("FAIL ht_idle va_req got=%b exp=00", va_request_o); end
    @(negedge clk);
    checks++; if (out_port_o[0] !== EAST) begin errors++; $display("FAIL ht_route got=%0d exp=%0d", out_port_o[0], EAST); end
    checks++; if (va_request_o !== 2'b01) begin errors++; $display("FAIL ht_va_req got=%b exp=01", va_request_o); end
    va_grant_i = 2'b01;
    @(negedge clk); va_grant_i = 2'b00;
    checks++; if (sa_request_o !== 2'b01 || va_request_o !== 2'b00) begin errors++; $display("FAIL ht_sa_req got=%b/%b exp=01/00", sa_request_o, va_request_o); end
    sa_grant_i = 2'b01;
    @(negedge clk); sa_grant_i = 2'b00;
    checks++; if (valid_flit_o !== 1'b1 || credit_o !== 2'b01) begin errors++; $display("FAIL ht_out got=%b/%b exp=1/01", valid_flit_o, credit_o); end
    f = (exp0_q.size() > 0) ? exp0_q.pop_front() : flit_t'(0);
    checks++; if (flit_o !== f) begin errors++; $display("FAIL ht_flit got=%h exp=%h", flit_o, f); end
    checks++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin errors++; $display("FAIL ht_idle_after got=%b/%b exp=00/00", va_request_o, sa_request_o); end
    @(negedge clk);
    checks++; if (valid_flit_o !== 1'b0 || credit_o !== 2'b00) begin errors++; $display("FAIL ht_pulse got=%b/%b exp=0/00", valid_flit_o, credit_o); end
  endtask

  task automatic test_packet();
    flit_t f, e;
    int span;
    do_reset();
    push_pkt(mk(HEAD, 1, 3, 1, 16'h20)); push_pkt(mk(BODY, 1, 0, 0, 16'h21));
    push_pkt(mk(BODY, 1, 0, 0, 16'h22)); push_pkt(mk(TAIL, 1, 0, 0, 16'h23));
    run(16, 2);
    span = (obs_cyc.size() == 4) ? obs_cyc[3] - obs_cyc[0] : -1;
    checks++; if (span !== 3) begin errors++; $display("FAIL pkt_consecutive got=%0d exp=3 (n=%0d)", span, obs_cyc.size()); end
    checks++; if (credit_cnt[1] !== 4 || credit_cnt[0] !== 0) begin errors++; $display("FAIL pkt_credits got=%0d/%0d exp=4/0", credit_cnt[1], credit_cnt[0]); end
    checks++; if (out_port_o[1] !== EAST) begin errors++; $display("FAIL pkt_route got=%0d exp=%0d", out_port_o[1], EAST); end
    checks++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin errors++; $display("FAIL pkt_idle got=%b/%b exp=00/00", va_request_o, sa_request_o); end
    while (obs_q.size() > 0) begin
      f = obs_q.pop_front();
      if (f.vc_id == 1) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : flit_t'(0);
      else              e = (exp1_q.size() > 0) ? exp1_q.pop_front() : flit_t'(0);
      checks++; if (f !== e) begin errors++; $display("FAIL pkt_flit got=%h exp=%h", f, e); end
    end
    checks++; if (exp0_q.size() + exp1_q.size() != 0) begin errors++; $display("FAIL pkt_missing got=%0d exp=0", exp0_q.size() + exp1_q.size()); end
  endtask

  task automatic test_overflow();
    flit_t f, e;
    do_reset();
    push_pkt(mk(HEAD, 0, 1, 0, 16'h100));
    for (int i = 1; i < 7; i++) push_pkt(mk(BODY, 0, 0, 0, 16'h100 + i));
    push_pkt(mk(TAIL, 0, 0, 0, 16'h107));
    wr_q.push_back(mk(HEADTAIL, 0, 1, 0, 16'h1FF));
    run(9, 0);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow_o); end
    run(2, 0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
    run(20, 0);
    checks++; if (overflow_o !== 1'b1 || obs_q.size() != 0) begin errors++; $display("FAIL ovf_sticky got=%b/%0d exp=1/0", overflow_o, obs_q.size()); end
    run(30, 2);
    checks++; if (credit_cnt[0] !== 8 || overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_drain got=%0d/%b exp=8/1", credit_cnt[0], overflow_o); end
    while (obs_q.size() > 0) begin
      f = obs_q.pop_front();
      if (f.vc_id == 1) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : flit_t'(0);
      else              e = (exp1_q.size() > 0) ? exp1_q.pop_front() : flit_t'(0);
      checks++; if (f !== e) begin errors++; $display("FAIL ovf_flit got=%h exp=%h", f, e); end
    end
    checks++; if (exp0_q.size() + exp1_q.size() != 0) begin errors++; $display("FAIL ovf_missing got=%0d exp=0", exp0_q.size() + exp1_q.size()); end
  endtask

  task automatic test_label_err();
    do_reset();
    wr_q.push_back(mk(BODY, 1, 0, 0, 16'hBAD));
    run(4, 1);
    checks++; if (overflow_o !== 1'b1 || va_request_o !== 2'b00) begin errors++; $display("FAIL lbl_err got=%b/%b exp=1/00", overflow_o, va_request_o); end
    @(negedge clk); sa_grant_i = 2'b10; va_grant_i = '0; valid_flit_i = 1'b0;
    @(negedge clk); sa_grant_i = 2'b00;
    checks++; if (valid_flit_o !== 1'b0 || credit_o !== 2'b00) begin errors++; $display("FAIL lbl_inelig got=%b/%b exp=0/00", valid_flit_o, credit_o); end
  endtask

  task automatic test_sa_multi();
    flit_t f, e;
    do_reset();
    push_pkt(mk(HEAD, 0, 1, 0, 16'h400)); push_pkt(mk(HEAD, 1, 2, 0, 16'h410));
    push_pkt(mk(TAIL, 0, 0, 0, 16'h401)); push_pkt(mk(TAIL, 1, 0, 0, 16'h411));
    run(8, 1);
    checks++; if (sa_request_o !== 2'b11) begin errors++; $display("FAIL multi_req got=%b exp=11", sa_request_o); end
    @(negedge clk); sa_grant_i = 2'b11; va_grant_i = '0; valid_flit_i = 1'b0;
    @(negedge clk); sa_grant_i = 2'b00;
    checks++; if (valid_flit_o !== 1'b0 || credit_o !== 2'b00) begin errors++; $display("FAIL multi_grant got=%b/%b exp=0/00", valid_flit_o, credit_o); end
    run(12, 2);
    checks++; if (credit_cnt[0] !== 2 || credit_cnt[1] !== 2) begin errors++; $display("FAIL multi_credits got=%0d/%0d exp=2/2", credit_cnt[0], credit_cnt[1]); end
    while (obs_q.size() > 0) begin
      f = obs_q.pop_front();
      if (f.vc_id == 1) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : flit_t'(0);
      else              e = (exp1_q.size() > 0) ? exp1_q.pop_front() : flit_t'(0);
      checks++; if (f !== e) begin errors++; $display("FAIL multi_flit got=%h exp=%h", f, e); end
    end
    checks++; if (exp0_q.size() + exp1_q.size() != 0) begin errors++; $display("FAIL multi_missing got=%0d exp=0", exp0_q.size() + exp1_q.size()); end
  endtask

  task automatic test_interleave();
    flit_label_t l0 [4] = '{HEAD, BODY, TAIL, HEADTAIL};
    flit_label_t l1 [6] = '{HEAD, BODY, BODY, TAIL, HEAD, TAIL};
    flit_t f, e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) push_pkt(mk(l0[k], 0, 1 + k, 0, 16'h500 + k));
      push_pkt(mk(l1[k], 1, 2, 0, 16'h600 + k));
    end
    run(60, 2);
    checks++; if (credit_cnt[0] !== 4 || credit_cnt[1] !== 6) begin errors++; $display("FAIL intl_credits got=%0d/%0d exp=4/6", credit_cnt[0], credit_cnt[1]); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL intl_ovf got=%b exp=0", overflow_o); end
    while (obs_q.size() > 0) begin
      f = obs_q.pop_front();
      if (f.vc_id == 1) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : flit_t'(0);
      else              e = (exp1_q.size() > 0) ? exp1_q.pop_front() : flit_t'(0);
      checks++; if (f !== e) begin errors++; $display("FAIL intl_flit got=%h exp=%h", f, e); end
    end
    checks++; if (exp0_q.size() + exp1_q.size() != 0) begin errors++; $display("FAIL intl_missing got=%0d exp=0", exp0_q.size() + exp1_q.size()); end
  endtask

  task automatic test_reset_mid();
    flit_t f, e;
    do_reset();
    wr_q.push_back(mk(HEAD, 0, 3, 0, 16'h700));
    wr_q.push_back(mk(BODY, 0, 0, 0, 16'h701));
    wr_q.push_back(mk(BODY, 0, 0, 0, 16'h702));
    run(6, 1);
    checks++; if (sa_request_o !== 2'b01) begin errors++; $display("FAIL rmid_setup got=%b exp=01", sa_request_o); end
    @(negedge clk); valid_flit_i = 1'b0; va_grant_i = '0; sa_grant_i = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({va_request_o, sa_request_o, credit_o, valid_flit_o} !== 7'b0 || out_port_o[0] !== LOCAL) begin
      errors++; $display("FAIL rmid_async got=%b/%0d exp=0/LOCAL", {va_request_o, sa_request_o, credit_o, valid_flit_o}, out_port_o[0]); end
    repeat (2) @(negedge clk);
    checks++; if (credit_cnt[0] !== 0 || obs_q.size() != 0) begin errors++; $display("FAIL rmid_credit got=%0d/%0d exp=0/0", credit_cnt[0], obs_q.size()); end
    rst = 1'b1;
    push_pkt(mk(HEADTAIL, 0, 1, 0, 16'h5A5A));
    run(10, 2);
    checks++; if (credit_cnt[0] !== 1 || out_port_o[0] !== EAST) begin errors++; $display("FAIL rmid_fresh got=%0d/%0d exp=1/EAST", credit_cnt[0], out_port_o[0]); end
    while (obs_q.size() > 0) begin
      f = obs_q.pop_front();
      if (f.vc_id == 1) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : flit_t'(0);
      else              e = (exp1_q.size() > 0) ? exp1_q.pop_front() : flit_t'(0);
      checks++; if (f !== e) begin errors++; $display("FAIL rmid_flit got=%h exp=%h", f, e); end
    end
    checks++; if (exp0_q.size() + exp1_q.size() != 0) begin errors++; $display("FAIL rmid_missing got=%0d exp=0", exp0_q.size() + exp1_q.size()); end
  endtask

  initial begin
    credit_cnt[0] = 0; credit_cnt[1] = 0;
    test_reset();
    test_headtail();
    test_packet();
    test_overflow();
    test_label_err();
    test_sa_multi();
    test_interleave();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
